// File: rtl/uart_tx_serializer.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, one stop bit.
// A post-frame guard window lets an upstream sender that holds load_byte refresh tx_byte.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int GUARD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       load_byte,
    output logic       tx_serial,
    output logic       byte_sent,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GUARD
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_bit, parity_next;
    logic [GW-1:0] guard_cnt, guard_next;
    logic          tx_next, sent_next, busy_next;
    logic          bit_done;

    function automatic logic calc_parity(input logic [7:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    assign bit_done = (baud_cnt == BAUD_LAST);

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            guard_cnt  <= '0;
            tx_serial  <= 1'b1;
            byte_sent  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_idx    <= bit_idx_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            guard_cnt  <= guard_next;
            tx_serial  <= tx_next;
            byte_sent  <= sent_next;
            busy       <= busy_next;
        end
    end

    // Next-state sequencing; outputs are derived from the next state so they register cleanly
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift_reg;
        parity_next   = parity_bit;
        guard_next    = guard_cnt;
        case (state)
            S_IDLE: begin
                if (load_byte) begin
                    shift_next    = tx_byte;
                    parity_next   = calc_parity(tx_byte);
                    baud_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    state_next    = S_START;
                end else begin
                    baud_cnt_next = '0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    baud_cnt_next = '0;
                    state_next    = S_DATA;
                end else begin
                    baud_cnt_next = baud_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_cnt_next = '0;
                    shift_next    = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = 3'd0;
                        state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    baud_cnt_next = '0;
                    state_next    = S_STOP;
                end else begin
                    baud_cnt_next = baud_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    baud_cnt_next = '0;
                    guard_next    = '0;
                    state_next    = S_GUARD;
                end else begin
                    baud_cnt_next = baud_cnt + CW'(1);
                end
            end
            S_GUARD: begin
                if (guard_cnt == GUARD_LAST) begin
                    guard_next = '0;
                    state_next = S_IDLE;
                end else begin
                    guard_next = guard_cnt + GW'(1);
                end
            end
            default: begin
                state_next    = S_IDLE;
                baud_cnt_next = '0;
                bit_idx_next  = 3'd0;
                guard_next    = '0;
            end
        endcase

        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = parity_next;
            default:  tx_next = 1'b1;
        endcase
        sent_next = (state_next == S_STOP) && (baud_cnt_next == BAUD_LAST);
        busy_next = (state_next != S_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed checks of uart_tx_serializer across several parameter sets, plus a full
// 256-value sweep decoded by a bit-centre sampler.
module tb_uart_tx_serializer;

    localparam int NK = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NK-1:0] rst;
    logic [NK-1:0] ld;
    logic [7:0]    byt [NK];
    wire  [NK-1:0] txs;
    wire  [NK-1:0] sent;
    wire  [NK-1:0] busy;

    int checks = 0;
    int failures = 0;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0), .GUARD_CYCLES(2)) u0 (
        .clk(clk), .reset(rst[0]), .tx_byte(byt[0]), .load_byte(ld[0]),
        .tx_serial(txs[0]), .byte_sent(sent[0]), .busy(busy[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(1), .GUARD_CYCLES(2)) u1 (
        .clk(clk), .reset(rst[1]), .tx_byte(byt[1]), .load_byte(ld[1]),
        .tx_serial(txs[1]), .byte_sent(sent[1]), .busy(busy[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(2), .GUARD_CYCLES(2)) u2 (
        .clk(clk), .reset(rst[2]), .tx_byte(byt[2]), .load_byte(ld[2]),
        .tx_serial(txs[2]), .byte_sent(sent[2]), .busy(busy[2]));
    uart_tx_serializer #(.CLKS_PER_BIT(2), .PARITY(1), .GUARD_CYCLES(2)) u3 (
        .clk(clk), .reset(rst[3]), .tx_byte(byt[3]), .load_byte(ld[3]),
        .tx_serial(txs[3]), .byte_sent(sent[3]), .busy(busy[3]));
    uart_tx_serializer #(.CLKS_PER_BIT(3), .PARITY(2), .GUARD_CYCLES(2)) u4 (
        .clk(clk), .reset(rst[4]), .tx_byte(byt[4]), .load_byte(ld[4]),
        .tx_serial(txs[4]), .byte_sent(sent[4]), .busy(busy[4]));
    uart_tx_serializer #(.CLKS_PER_BIT(16), .PARITY(0), .GUARD_CYCLES(2)) u5 (
        .clk(clk), .reset(rst[5]), .tx_byte(byt[5]), .load_byte(ld[5]),
        .tx_serial(txs[5]), .byte_sent(sent[5]), .busy(busy[5]));

    function automatic int nclk(input int k);
        case (k)
            3:       return 2;
            4:       return 3;
            5:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int par(input int k);
        case (k)
            1, 3:    return 1;
            2, 4:    return 2;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request one byte with a single-cycle pulse; returns at the sample point of frame cycle 1.
    task automatic load(input int k, input logic [7:0] data);
        byt[k] = data;
        ld[k]  = 1'b1;
        @(negedge clk);
        ld[k]  = 1'b0;
    endtask

    // Check every cycle of a frame; exp holds one character per bit time.
    task automatic frame(input int k, input string exp, input bit intrude);
        int n = nclk(k);
        int f = exp.len() * n;
        for (int c = 1; c <= f; c++) begin
            int bi = (c - 1) / n;
            chk($sformatf("tx k%0d c%0d", k, c), {7'd0, txs[k]}, (exp[bi] == 8'h31) ? 8'd1 : 8'd0);
            chk($sformatf("sent k%0d c%0d", k, c), {7'd0, sent[k]}, (c == f) ? 8'd1 : 8'd0);
            chk($sformatf("busy k%0d c%0d", k, c), {7'd0, busy[k]}, 8'd1);
            if (intrude && c == 3 * n + 2) begin
                byt[k] = 8'h3C;
                ld[k]  = 1'b1;
            end else if (intrude && c == 3 * n + 3) begin
                ld[k]  = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Two guard cycles (busy high) then one idle cycle, all with the line at mark.
    task automatic guard(input int k);
        for (int g = 1; g <= 3; g++) begin
            chk($sformatf("guard_tx k%0d g%0d", k, g), {7'd0, txs[k]}, 8'd1);
            chk($sformatf("guard_sent k%0d g%0d", k, g), {7'd0, sent[k]}, 8'd0);
            chk($sformatf("guard_busy k%0d g%0d", k, g), {7'd0, busy[k]}, (g <= 2) ? 8'd1 : 8'd0);
            @(negedge clk);
        end
    endtask

    task automatic quiet(input int k, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            chk($sformatf("quiet k%0d c%0d", k, c),
                {5'd0, txs[k], busy[k], sent[k]}, 8'b0000_0100);
            @(negedge clk);
        end
    endtask

    // All 256 values in a random odd-stride order, decoded at bit centres.
    task automatic sweep(input int k);
        int n  = nclk(k);
        int p  = par(k);
        int nb = (p != 0) ? 11 : 10;
        int mult = $urandom_range(0, 127) * 2 + 1;
        int off  = $urandom_range(0, 255);
        for (int i = 0; i < 256; i++) begin
            logic [7:0]  v;
            logic [10:0] rx;
            logic        sent_ok, sent_early;
            v = 8'((i * mult + off) % 256);
            rx = 11'd0;
            sent_ok = 1'b0;
            sent_early = 1'b0;
            load(k, v);
            for (int c = 1; c <= nb * n; c++) begin
                if ((c - 1) % n == n / 2) rx[(c - 1) / n] = txs[k];
                if (c == nb * n) sent_ok = sent[k];
                else if (sent[k]) sent_early = 1'b1;
                @(negedge clk);
            end
            chk($sformatf("sw_start k%0d v%0h", k, v), {7'd0, rx[0]}, 8'd0);
            chk($sformatf("sw_data k%0d", k), rx[8:1], v);
            if (p != 0)
                chk($sformatf("sw_par k%0d v%0h", k, v), {7'd0, rx[9]},
                    {7'd0, (p == 1) ? ^v : ~(^v)});
            chk($sformatf("sw_stop k%0d v%0h", k, v), {7'd0, rx[nb - 1]}, 8'd1);
            chk($sformatf("sw_sent k%0d v%0h", k, v), {6'd0, sent_ok, sent_early}, 8'b0000_0010);
            guard(k);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] data;
        string      exp;
        bit         intrude;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{0, 8'h61, "0100001101", 1'b1};
        vecs[1] = '{0, 8'hA5, "0101001011", 1'b0};
        vecs[2] = '{1, 8'h07, "01110000011", 1'b0};
        vecs[3] = '{2, 8'h07, "01110000001", 1'b0};
        vecs[4] = '{1, 8'h00, "00000000001", 1'b0};
        vecs[5] = '{2, 8'hFF, "01111111111", 1'b0};
        vecs[6] = '{1, 8'h80, "00000000111", 1'b0};

        rst = '1;
        ld  = '0;
        for (int k = 0; k < NK; k++) byt[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", {2'd0, txs}, 8'h3F);
        chk("reset_busy", {2'd0, busy}, 8'h00);
        chk("reset_sent", {2'd0, sent}, 8'h00);
        rst = '0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].k, vecs[i].data);
            frame(vecs[i].k, vecs[i].exp, vecs[i].intrude);
            guard(vecs[i].k);
            if (vecs[i].intrude) quiet(vecs[i].k, 8);
        end

        // load_byte held high; tx_byte updated one cycle after byte_sent
        byt[0] = 8'h68;
        ld[0]  = 1'b1;
        @(negedge clk);
        frame(0, "0000101101", 1'b0);
        byt[0] = 8'h69;
        guard(0);
        frame(0, "0100101101", 1'b0);
        ld[0] = 1'b0;
        guard(0);
        quiet(0, 12);

        // Reset during data bit 4 aborts the frame silently
        load(0, 8'h61);
        repeat (21) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("midreset_tx", {7'd0, txs[0]}, 8'd1);
        chk("midreset_busy", {7'd0, busy[0]}, 8'd0);
        chk("midreset_sent", {7'd0, sent[0]}, 8'd0);
        rst[0] = 1'b0;
        quiet(0, 48);
        load(0, 8'h61);
        frame(0, "0100001101", 1'b0);
        guard(0);

        sweep(3);
        sweep(4);
        sweep(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmitter that turns parallel bytes into an asynchronous serial frame on `tx_serial`. It sits directly downstream of the chat-bot message sender. It consumes that block's `byte_out`/`load_byte` pair and returns a one-cycle `byte_sent` pulse after each frame's stop bit completes, which tells the sender to present the next byte. Framing is 8 data bits, LSB first, optional parity, one stop bit.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (≥2); 434 gives 115200 baud at 50 MHz.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- GUARD_CYCLES, 2, idle cycles after `byte_sent` during which `load_byte` is ignored (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset reset, synchronous, active-high; clock clk.
- tx_byte  in  8  byte to transmit; sampled only on the accepting edge.
- load_byte  in  1  level request to send `tx_byte`; may be held high across consecutive bytes.
- tx_serial  out  1  serial line; idle/mark = 1.
- byte_sent  out  1  one-cycle pulse, last cycle of stop bit.
- busy  out  1  high from accept until end of guard period.

## Operation
- State machine: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → GUARD → IDLE.
- IDLE: `tx_serial`=1, `busy`=0. If `load_byte`=1 at a rising edge: latch `tx_byte` into shift register, compute the parity bit, clear the baud counter and bit index, enter START.
- START: `tx_serial`=0 for CLKS_PER_BIT cycles.
- DATA: output shift_reg[0], CLKS_PER_BIT cycles per bit, shift right after each bit; bit index 0..7; leave DATA after bit 7.
- PARITY: even parity = XOR of the 8 latched bits; odd parity = its inverse; one bit time.
- STOP: `tx_serial`=1 for CLKS_PER_BIT cycles; `byte_sent`=1 in the final cycle only.
- GUARD: `tx_serial`=1, `busy`=1, `load_byte` ignored for GUARD_CYCLES cycles, then IDLE. The guard gives an upstream sender that holds `load_byte` high time to update `tx_byte`, which it does within 2 cycles of `byte_sent`.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 on the bit-advance cycle; no drift accumulates across bits.
- `load_byte` outside IDLE: ignored; the request is not queued.
- `tx_byte` changes after the accepting edge: no effect on the frame in progress.
- Reset, including mid-frame: state=IDLE, `tx_serial`=1, `byte_sent`=0, `busy`=0, counters=0, shift register=0, effective at the next edge. No `byte_sent` is issued for an aborted frame. Reset has priority over `load_byte`.
- All outputs are registered; no combinational input→output path.

## Timing
- Accept edge E: `tx_serial` falls and `busy` rises in the cycle after E.
- Frame length F = (10 + (PARITY≠0)) × CLKS_PER_BIT cycles, measured from the `tx_serial` falling edge.
- `byte_sent` is high in cycle F (counting the first START cycle as 1).
- Earliest next accept: the edge GUARD_CYCLES+1 cycles after the `byte_sent` cycle.
- Back-to-back throughput with `load_byte` held high: one byte per F + GUARD_CYCLES + 1 cycles.
- `byte_sent` is never asserted in consecutive cycles, and never while in IDLE.

## Test plan
- CLKS_PER_BIT=4, PARITY=0, `tx_byte`=0x61 with a one-cycle `load_byte` → `tx_serial` shows 0,1,0,0,0,0,1,1,0,1, each 4 cycles; `byte_sent` pulses in cycle 40; `busy` low 3 cycles later.
- PARITY=1 with 0x07 → parity bit 1; PARITY=2 with 0x07 → parity bit 0; frame is 44 cycles; `byte_sent` in cycle 44.
- `load_byte` held high, `tx_byte` changed from 0x68 to 0x69 one cycle after `byte_sent` → two frames: 0x68, then 0x69, with exactly 3 idle-high cycles between the stop bit and the next start bit; no duplicate 0x68.
- `load_byte` pulsed in mid-DATA with a different byte → ignored; the frame is unchanged; only one `byte_sent`.
- Reset asserted during bit 4 of DATA → `tx_serial`=1 and `busy`=0 the next cycle; no `byte_sent`; a new load after reset transmits a correct full frame.
- Randomized CLKS_PER_BIT ∈ {2,3,16} with a serial-line checker sampling at bit centres → all 256 byte values recovered and the parity bit correct for each.
